// File: rtl/seq_match_fsm.sv
// Streaming symbol-sequence detector: tracks the longest matched prefix of a
// programmable pattern and reports each full-sequence hit with a saturating count.
module seq_match_fsm #(
  parameter int W       = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [W-1:0]                 x,
  input  logic                         cfg_load,
  input  logic [W*DEPTH-1:0]           cfg_pattern,
  input  logic                         cnt_clear,
  output logic                         match,
  output logic [$clog2(DEPTH+1)-1:0]   progress,
  output logic [CNT_W-1:0]             match_count,
  output logic                         count_sat
);

  localparam int PW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_HIT
  } state_t;

  state_t                 state_p1, state_nxt;
  logic [W*DEPTH-1:0]     pattern_p1, pattern_nxt;
  logic [W-1:0]           hist_p1 [DEPTH-1];
  logic [W-1:0]           win [DEPTH];
  logic [PW-1:0]          hist_len_p1, hist_len_nxt, new_len;
  logic [PW-1:0]          progress_p1, progress_nxt;
  logic [PW-1:0]          k_full, k_part;
  logic [CNT_W-1:0]       count_p1, count_nxt;
  logic                   accept, hit, ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Window of the most recent symbols, newest (the incoming x) at index 0.
  always_comb begin
    win[0] = x;
    for (int i = 1; i < DEPTH; i++) begin
      win[i] = hist_p1[i-1];
    end
  end

  assign accept  = in_valid && !cfg_load;
  assign new_len = (hist_len_p1 == PW'(DEPTH)) ? hist_len_p1 : hist_len_p1 + PW'(1);

  // Longest suffix of the window equal to a pattern prefix, both unrestricted
  // (k_full) and strictly shorter than the full pattern (k_part, for overlap).
  always_comb begin
    k_full = '0;
    k_part = '0;
    ok     = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      ok = (k <= int'(new_len));
      for (int j = 0; j < k; j++) begin
        if (win[k-1-j] != pattern_p1[W*j +: W]) ok = 1'b0;
      end
      if (ok) begin
        k_full = PW'(k);
        if (k < DEPTH) k_part = PW'(k);
      end
    end
  end

  assign hit = accept && (k_full == PW'(DEPTH));

  always_comb begin
    pattern_nxt  = pattern_p1;
    hist_len_nxt = hist_len_p1;
    progress_nxt = progress_p1;
    count_nxt    = count_p1;
    state_nxt    = (hist_len_p1 == '0) ? ST_EMPTY : ST_ACTIVE;

    if (cfg_load) begin
      pattern_nxt  = cfg_pattern;
      hist_len_nxt = '0;
      progress_nxt = '0;
      state_nxt    = ST_EMPTY;
    end else if (accept) begin
      if (hit) begin
        state_nxt = ST_HIT;
        if (OVERLAP != 0) begin
          progress_nxt = k_part;
          hist_len_nxt = new_len;
        end else begin
          progress_nxt = '0;
          hist_len_nxt = '0;
        end
      end else begin
        progress_nxt = k_full;
        hist_len_nxt = new_len;
        state_nxt    = ST_ACTIVE;
      end
    end

    // Clear beats a coincident match; load leaves the count alone.
    if (cnt_clear) begin
      count_nxt = '0;
    end else if (hit) begin
      count_nxt = sat_inc(count_p1);
    end
  end

  // Stage p1: control and configuration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= ST_EMPTY;
      pattern_p1  <= '0;
      hist_len_p1 <= '0;
      progress_p1 <= '0;
      count_p1    <= '0;
    end else begin
      state_p1    <= state_nxt;
      pattern_p1  <= pattern_nxt;
      hist_len_p1 <= hist_len_nxt;
      progress_p1 <= progress_nxt;
      count_p1    <= count_nxt;
    end
  end

  // Stage p1: symbol history; validity is tracked solely by hist_len_p1.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        hist_p1[i] <= win[i];
      end
    end
  end

  assign match       = (state_p1 == ST_HIT);
  assign progress    = progress_p1;
  assign match_count = count_p1;
  assign count_sat   = &count_p1;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Scoreboard bench for seq_match_fsm: three instances (overlap, restart,
// 2-bit counter) share one stimulus stream; expectations are hand-computed.
`timescale 1ns/100ps
module tb_seq_match_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, cfg_load, cnt_clear;
  logic [1:0] x;
  logic [7:0] cfg_pattern;

  logic       m0, m1, m2, s0, s1, s2;
  logic [2:0] p0, p1, p2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string nm;
    int    sel;
    logic  m;
    int    p;
    int    c;
    logic  s;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seq_match_fsm #(.W(2), .DEPTH(4), .CNT_W(8), .OVERLAP(1)) u_ov (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clear(cnt_clear), .match(m0), .progress(p0),
    .match_count(c0), .count_sat(s0));

  seq_match_fsm #(.W(2), .DEPTH(4), .CNT_W(8), .OVERLAP(0)) u_no (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clear(cnt_clear), .match(m1), .progress(p1),
    .match_count(c1), .count_sat(s1));

  seq_match_fsm #(.W(2), .DEPTH(4), .CNT_W(2), .OVERLAP(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clear(cnt_clear), .match(m2), .progress(p2),
    .match_count(c2), .count_sat(s2));

  task automatic ex(input string nm, input int sel, input logic m, input int p,
                    input int c, input logic s);
    exp_t e;
    e.nm = nm; e.sel = sel; e.m = m; e.p = p; e.c = c; e.s = s;
    q.push_back(e);
  endtask

  // Apply inputs for one edge, then return 1ns after it with inputs idle.
  task automatic step(input logic v, input logic [1:0] sym, input logic ld,
                      input logic clr);
    in_valid = v; x = sym; cfg_load = ld; cnt_clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clear = 1'b0;
  endtask

  // Monitor: samples mid-cycle, and also right after an asynchronous reset.
  initial begin
    exp_t e;
    logic am, as;
    int   ap, ac;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin am = m0; ap = int'(p0); ac = int'(c0); as = s0; end
          1:       begin am = m1; ap = int'(p1); ac = int'(c1); as = s1; end
          default: begin am = m2; ap = int'(p2); ac = int'(c2); as = s2; end
        endcase
        n_tests++;
        if (am !== e.m || ap != e.p || ac != e.c || as !== e.s) begin
          n_fail++;
          $display("FAIL %s (dut%0d): got match=%0b progress=%0d count=%0d sat=%0b, want match=%0b progress=%0d count=%0d sat=%0b",
                   e.nm, e.sel, am, ap, ac, as, e.m, e.p, e.c, e.s);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clear = 1'b0;
    x = 2'd0; cfg_pattern = 8'h00;
    #2;
    ex("reset_ov", 0, 0, 0, 0, 0);
    ex("reset_no", 1, 0, 0, 0, 0);
    ex("reset_sat", 2, 0, 0, 0, 0);
    #10;
    rst_n = 1'b1;

    // Basic match 0,1,2,3.
    cfg_pattern = 8'hE4;
    step(1, 2'd0, 1, 1); ex("a_load", 0, 0, 0, 0, 0);
    step(1, 2'd0, 0, 0); ex("a_s0", 0, 0, 1, 0, 0);
    step(1, 2'd1, 0, 0); ex("a_s1", 0, 0, 2, 0, 0);
    step(1, 2'd2, 0, 0); ex("a_s2", 0, 0, 3, 0, 0);
    step(1, 2'd3, 0, 0); ex("a_s3", 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 0); ex("a_idle", 0, 0, 0, 1, 0);

    // Overlap vs restart on 1,1,1,1.
    cfg_pattern = 8'h55;
    step(0, 2'd0, 1, 1); ex("b_load_ov", 0, 0, 0, 0, 0); ex("b_load_no", 1, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0); ex("b1_ov", 0, 0, 1, 0, 0); ex("b1_no", 1, 0, 1, 0, 0);
    step(1, 2'd1, 0, 0); ex("b2_ov", 0, 0, 2, 0, 0); ex("b2_no", 1, 0, 2, 0, 0);
    step(1, 2'd1, 0, 0); ex("b3_ov", 0, 0, 3, 0, 0); ex("b3_no", 1, 0, 3, 0, 0);
    step(1, 2'd1, 0, 0); ex("b4_ov", 0, 1, 3, 1, 0); ex("b4_no", 1, 1, 0, 1, 0);
    step(1, 2'd1, 0, 0); ex("b5_ov", 0, 1, 3, 2, 0); ex("b5_no", 1, 0, 1, 1, 0);
    step(1, 2'd1, 0, 0); ex("b6_ov", 0, 1, 3, 3, 0); ex("b6_no", 1, 0, 2, 1, 0);
    step(0, 2'd0, 0, 0); ex("b_idle_ov", 0, 0, 3, 3, 0); ex("b_idle_no", 1, 0, 2, 1, 0);

    // Mismatch recovery: pattern 0,0,0,1 fed 0,0,0,0,1.
    cfg_pattern = 8'h40;
    step(0, 2'd0, 1, 1); ex("c_load", 0, 0, 0, 0, 0);
    step(1, 2'd0, 0, 0); ex("c1", 0, 0, 1, 0, 0);
    step(1, 2'd0, 0, 0); ex("c2", 0, 0, 2, 0, 0);
    step(1, 2'd0, 0, 0); ex("c3", 0, 0, 3, 0, 0);
    step(1, 2'd0, 0, 0); ex("c4", 0, 0, 3, 0, 0);
    step(1, 2'd1, 0, 0); ex("c5", 0, 1, 0, 1, 0);

    // Gaps between symbols give the same result.
    cfg_pattern = 8'hE4;
    step(0, 2'd0, 1, 1); ex("d_load", 0, 0, 0, 0, 0);
    step(1, 2'd0, 0, 0); ex("d_s0", 0, 0, 1, 0, 0);
    step(0, 2'd2, 0, 0); ex("d_gap0", 0, 0, 1, 0, 0);
    step(1, 2'd1, 0, 0); ex("d_s1", 0, 0, 2, 0, 0);
    step(0, 2'd3, 0, 0); ex("d_gap1a", 0, 0, 2, 0, 0);
    step(0, 2'd0, 0, 0); ex("d_gap1b", 0, 0, 2, 0, 0);
    step(1, 2'd2, 0, 0); ex("d_s2", 0, 0, 3, 0, 0);
    step(0, 2'd3, 0, 0); ex("d_gap2", 0, 0, 3, 0, 0);
    step(1, 2'd3, 0, 0); ex("d_s3", 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 0); ex("d_idle", 0, 0, 0, 1, 0);

    // Load coincident with the final symbol discards it.
    step(1, 2'd0, 0, 0); ex("e_s0", 0, 0, 1, 1, 0);
    step(1, 2'd1, 0, 0); ex("e_s1", 0, 0, 2, 1, 0);
    step(1, 2'd2, 0, 0); ex("e_s2", 0, 0, 3, 1, 0);
    step(1, 2'd3, 1, 0); ex("e_load_s3", 0, 0, 0, 1, 0);
    step(1, 2'd3, 0, 0); ex("e_lone3", 0, 0, 0, 1, 0);

    // Clear coincident with a match: pulse still seen, count zero.
    step(1, 2'd0, 0, 0); ex("f_s0", 0, 0, 1, 1, 0);
    step(1, 2'd1, 0, 0); ex("f_s1", 0, 0, 2, 1, 0);
    step(1, 2'd2, 0, 0); ex("f_s2", 0, 0, 3, 1, 0);
    step(1, 2'd3, 0, 1); ex("f_clr_match", 0, 1, 0, 0, 0);
    step(0, 2'd0, 0, 0); ex("f_idle", 0, 0, 0, 0, 0);

    // Saturation on the 2-bit counter instance.
    step(0, 2'd0, 1, 1); ex("g_load", 2, 0, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      step(1, 2'd0, 0, 0); ex("g_s0", 2, 0, 1, (r > 3) ? 3 : r, r >= 3);
      step(1, 2'd1, 0, 0); ex("g_s1", 2, 0, 2, (r > 3) ? 3 : r, r >= 3);
      step(1, 2'd2, 0, 0); ex("g_s2", 2, 0, 3, (r > 3) ? 3 : r, r >= 3);
      step(1, 2'd3, 0, 0); ex("g_match", 2, 1, 0, (r + 1 > 3) ? 3 : r + 1, r >= 2);
    end

    // Asynchronous reset mid-sequence, then reload and feed the final symbol.
    step(0, 2'd0, 1, 1); ex("h_load", 0, 0, 0, 0, 0);
    step(1, 2'd0, 0, 0); ex("h_s0", 0, 0, 1, 0, 0);
    step(1, 2'd1, 0, 0); ex("h_s1", 0, 0, 2, 0, 0);
    step(1, 2'd2, 0, 0); ex("h_s2", 0, 0, 3, 0, 0);
    step(0, 2'd0, 0, 0); ex("h_hold", 0, 0, 3, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ex("h_async_reset", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    step(0, 2'd0, 1, 0); ex("h_reload", 0, 0, 0, 0, 0);
    step(1, 2'd3, 0, 0); ex("h_feed3", 0, 0, 0, 0, 0);
    step(0, 2'd0, 0, 0); ex("h_idle", 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #7;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_fsm.md
SEQ_MATCH_FSM -- requirements
Module: seq_match_fsm

Interface
REQ-001 The block SHALL have parameter W, default 2, meaning input symbol width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning sequence length in symbols (2..16).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = restart after each match.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the symbol on x is accepted on this edge.
REQ-008 The block SHALL have port x, input, W bits: input symbol.
REQ-009 The block SHALL have port cfg_load, input, 1 bit: latch cfg_pattern and flush history.
REQ-010 The block SHALL have port cfg_pattern, input, W*DEPTH bits: symbol i at bits [W*i+W-1:W*i], and symbol 0 is expected first.
REQ-011 The block SHALL have port cnt_clear, input, 1 bit: zero match_count.
REQ-012 The block SHALL have port match, output, 1 bit: registered one-cycle pulse on sequence completion.
REQ-013 The block SHALL have port progress, output, clog2(DEPTH+1) bits: current matched-prefix length.
REQ-014 The block SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-015 The block SHALL have port count_sat, output, 1 bit: high while match_count equals all-ones.

Function
REQ-016 The block SHALL hold an internal pattern register, loaded from cfg_pattern on any edge with cfg_load=1.
REQ-017 The block SHALL hold a history of up to DEPTH accepted symbols, counted only since the last flush. A flush is caused by reset, cfg_load, or a match with OVERLAP=0.
REQ-018 On an accepted symbol, the block SHALL compute k as the largest value in 0..DEPTH for which the last k history symbols, including x, equal pattern symbols 0..k-1.
REQ-019 If k<DEPTH, the block SHALL set progress to k on that edge and leave match low on the next cycle.
REQ-020 If k=DEPTH, match SHALL be 1 for exactly the cycle following the accepting edge.
REQ-021 On a match with OVERLAP=1, progress SHALL become the largest k'<DEPTH satisfying the same prefix/suffix rule, and history SHALL be retained.
REQ-022 On a match with OVERLAP=0, progress SHALL become 0 and history SHALL be flushed.
REQ-023 With in_valid=0, progress, history, and match_count SHALL hold, and match SHALL be 0 the next cycle.
REQ-024 Each match SHALL increment match_count by 1. The count SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 Simultaneous cnt_clear and match SHALL leave match_count at 0, with clear winning; the match pulse SHALL still be emitted.
REQ-026 Simultaneous cfg_load and in_valid SHALL apply the load, discard the symbol, set progress to 0, and assert no match.
REQ-027 cfg_load SHALL NOT alter match_count.
REQ-028 count_sat SHALL be a combinational decode of match_count.

Reset
REQ-029 When rst_n=0, the block SHALL immediately clear the following, regardless of clk: match=0, progress=0, match_count=0, pattern register=0, history flushed.
REQ-030 Reset asserted mid-sequence SHALL discard all partial progress; no match SHALL be reported from symbols accepted before reset.
REQ-031 After rst_n deasserts, the first accepted symbol SHALL be evaluated against the all-zero pattern until cfg_load is applied.

Verification (W=2, DEPTH=4, CNT_W=8 unless stated)
REQ-032 Basic match: the bench SHALL cover this scenario. Stimulus: load 0xE4 (sequence 0,1,2,3), then feed 0,1,2,3. Required response: progress 1,2,3; match pulse one cycle after the 4th symbol; match_count=1.
REQ-033 Overlap: the bench SHALL cover this scenario. Stimulus: load 0x55 (1,1,1,1), then feed six 1s. Required response: OVERLAP=1 gives matches on symbols 4, 5 and 6, count=3, progress=3 after each; OVERLAP=0 gives a match on symbol 4 only, count=1, progress=2 at end.
REQ-034 Mismatch recovery: the bench SHALL cover this scenario. Stimulus: load 0x40 (0,0,0,1), then feed 0,0,0,0,1. Required response: progress 1,2,3,3; match after the 5th symbol.
REQ-035 Gaps and simultaneity: the bench SHALL cover this scenario. Stimulus: the REQ-032 stream with in_valid low cycles interleaved. Required response: identical result. Also cfg_load during symbol 3 gives progress 0 and no match; cnt_clear coincident with a match gives match=1 and count=0.
REQ-036 Saturation: the bench SHALL cover this scenario. Stimulus: CNT_W=2, five matches. Required response: count 1,2,3,3,3; count_sat high from the 3rd match.
REQ-037 Reset mid-operation: the bench SHALL cover this scenario. Stimulus: progress=3, pulse rst_n low between edges, reload 0xE4, feed 3. Required response: all outputs 0 immediately on reset; no match from the fed 3.
